// File: rtl/fifo_stream_reader_if.sv
// ============================================================================
// Module   : fifo_stream_reader_if
// Brief    : FIFO read port plus valid/ready beat stream for fifo_stream_reader
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_stream_reader_if #(
   parameter int DWIDTH = 16,
   parameter int OWIDTH = 8
);
   logic              fifo_rd_en;
   logic [DWIDTH-1:0] fifo_dout;
   logic              fifo_empty;
   logic [OWIDTH-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   // master: the reader itself; slave: FIFO plus downstream consumer side
   modport master (
      output fifo_rd_en,
      input  fifo_dout,
      input  fifo_empty,
      output m_data,
      output m_valid,
      input  m_ready,
      output m_last
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_dout,
      output fifo_empty,
      input  m_data,
      input  m_valid,
      output m_ready,
      input  m_last
   );
endinterface

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Drains a 1-cycle-latency FIFO and serializes each word MSB-first
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
   parameter int DWIDTH = 16,
   parameter int OWIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en,
   output logic                 busy,
   fifo_stream_reader_if.master bus
);

   localparam int RATIO = DWIDTH / OWIDTH;
   localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [BW-1:0] c_last_beat = BW'(RATIO - 1);

   logic              r_pend;
   logic [1:0]        r_qcnt;
   logic [DWIDTH-1:0] r_q0;
   logic [DWIDTH-1:0] r_q1;
   logic [DWIDTH-1:0] r_sword;
   logic              r_svalid;
   logic [BW-1:0]     r_beat;

   logic w_credit;
   logic w_rd_en;
   logic w_accept;
   logic w_last;
   logic w_ser_free;
   logic w_load_q;
   logic w_bypass;
   logic w_push;
   logic w_qidx;

   // A read is only issued when the queue can absorb it even if the
   // serializer stalls: q_count + pend must stay below the 2-entry depth.
   assign w_credit   = (r_qcnt == 2'd0) || ((r_qcnt == 2'd1) && !r_pend);
   assign w_rd_en    = rstn && en && !bus.fifo_empty && w_credit;

   assign w_accept   = r_svalid && bus.m_ready;
   assign w_last     = (r_beat == c_last_beat);
   assign w_ser_free = !r_svalid || (w_accept && w_last);
   assign w_load_q   = w_ser_free && (r_qcnt != 2'd0);
   assign w_bypass   = w_ser_free && r_pend && (r_qcnt == 2'd0);
   assign w_push     = r_pend && !w_bypass;

   // Slot for an incoming word after accounting for a same-cycle pop
   assign w_qidx     = w_load_q ? (r_qcnt == 2'd2) : (r_qcnt != 2'd0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pend <= 1'b0;
         r_qcnt <= 2'd0;
         r_q0   <= '0;
         r_q1   <= '0;
      end else begin
         r_pend <= w_rd_en;

         if (w_push && !w_load_q) begin
            r_qcnt <= r_qcnt + 2'd1;
         end else if (w_load_q && !w_push) begin
            r_qcnt <= r_qcnt - 2'd1;
         end

         if (w_load_q) begin
            r_q0 <= r_q1;
         end
         if (w_push) begin
            if (w_qidx) begin
               r_q1 <= bus.fifo_dout;
            end else begin
               r_q0 <= bus.fifo_dout;
            end
         end
      end
   end

   // The serializer word is shifted left per beat so the output is always
   // its top OWIDTH bits; r_beat only tracks position for m_last.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sword  <= '0;
         r_svalid <= 1'b0;
         r_beat   <= '0;
      end else if (w_load_q) begin
         r_sword  <= r_q0;
         r_svalid <= 1'b1;
         r_beat   <= '0;
      end else if (w_bypass) begin
         r_sword  <= bus.fifo_dout;
         r_svalid <= 1'b1;
         r_beat   <= '0;
      end else if (w_accept) begin
         if (w_last) begin
            r_svalid <= 1'b0;
            r_beat   <= '0;
         end else begin
            r_sword  <= r_sword << OWIDTH;
            r_beat   <= r_beat + BW'(1);
         end
      end
   end

   assign bus.fifo_rd_en = w_rd_en;
   assign bus.m_data     = r_sword[DWIDTH-1 -: OWIDTH];
   assign bus.m_valid    = r_svalid;
   assign bus.m_last     = r_svalid && w_last;
   assign busy           = r_pend || (r_qcnt != 2'd0) || r_svalid;

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
// Module   : tb_fifo_stream_reader
// Brief    : Bench for fifo_stream_reader at RATIO=2 (dut0) and RATIO=1 (dut1)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        en0, en1, busy0, busy1;
   logic        wr0, wr1;
   logic [15:0] wd0, wd1;

   int nvec = 0;
   int nerr = 0;

   logic [15:0] fq0[$];
   logic [15:0] fq1[$];
   logic [8:0]  cap0[$];
   logic [16:0] cap1[$];
   int          rdcnt0 = 0, rdcnt1 = 0, viol0 = 0, viol1 = 0;
   logic        pv0, pv1;
   logic [8:0]  pb0;
   logic [16:0] pb1;

   fifo_stream_reader_if #(.DWIDTH(16), .OWIDTH(8))  if0 ();
   fifo_stream_reader_if #(.DWIDTH(16), .OWIDTH(16)) if1 ();

   fifo_stream_reader #(.DWIDTH(16), .OWIDTH(8)) u_dut0 (
      .clk(clk), .rstn(rstn), .en(en0), .busy(busy0), .bus(if0));
   fifo_stream_reader #(.DWIDTH(16), .OWIDTH(16)) u_dut1 (
      .clk(clk), .rstn(rstn), .en(en1), .busy(busy1), .bus(if1));

   // FIFO models: 1-cycle read latency, empty flag updated at the edge
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fq0.delete();
         if0.fifo_empty <= 1'b1;
      end else begin
         if (if0.fifo_rd_en && fq0.size() != 0) if0.fifo_dout <= fq0.pop_front();
         if (wr0) fq0.push_back(wd0);
         if0.fifo_empty <= (fq0.size() == 0);
      end
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fq1.delete();
         if1.fifo_empty <= 1'b1;
      end else begin
         if (if1.fifo_rd_en && fq1.size() != 0) if1.fifo_dout <= fq1.pop_front();
         if (wr1) fq1.push_back(wd1);
         if1.fifo_empty <= (fq1.size() == 0);
      end
   end

   // Handshake monitors: record accepted beats, read strobes, protocol slips
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pv0 <= 1'b0;
      end else begin
         if (if0.m_valid && if0.m_ready) cap0.push_back({if0.m_last, if0.m_data});
         if (if0.fifo_rd_en) rdcnt0 <= rdcnt0 + 1;
         viol0 <= viol0 + int'(if0.fifo_rd_en && if0.fifo_empty)
                        + int'(pv0 && (!if0.m_valid || {if0.m_last, if0.m_data} != pb0));
         pv0 <= if0.m_valid && !if0.m_ready;
         pb0 <= {if0.m_last, if0.m_data};
      end
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pv1 <= 1'b0;
      end else begin
         if (if1.m_valid && if1.m_ready) cap1.push_back({if1.m_last, if1.m_data});
         if (if1.fifo_rd_en) rdcnt1 <= rdcnt1 + 1;
         viol1 <= viol1 + int'(if1.fifo_rd_en && if1.fifo_empty)
                        + int'(pv1 && (!if1.m_valid || {if1.m_last, if1.m_data} != pb1));
         pv1 <= if1.m_valid && !if1.m_ready;
         pb1 <= {if1.m_last, if1.m_data};
      end
   end

   // Reference: beat k of a 16-bit word at 8-bit beats, MSB first, with last flag
   function automatic logic [8:0] ref8(input logic [15:0] w, input int k);
      logic [15:0] s;
      s = (w >> (8 * (1 - k))) & 16'h00FF;
      return {(k == 1), s[7:0]};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push0(input logic [15:0] w);
      wr0 = 1'b1; wd0 = w;
      @(negedge clk);
      wr0 = 1'b0;
   endtask

   task automatic push1(input logic [15:0] w);
      wr1 = 1'b1; wd1 = w;
      @(negedge clk);
      wr1 = 1'b0;
   endtask

   task automatic test_reset();
      int hits;
      en0 = 1'b1; if0.m_ready = 1'b0;
      push0(16'hC3C3);
      tick(4);
      nvec++;
      if ({if0.m_valid, if0.m_data} !== 9'h1C3) begin
         nerr++; $display("FAIL reset_prefill: got %h want %h", {if0.m_valid, if0.m_data}, 9'h1C3);
      end
      #2 rstn = 1'b0;
      #1;
      nvec++;
      if ({if0.fifo_rd_en, if0.m_valid, if0.m_last, if0.m_data, busy0} !== 12'h0) begin
         nerr++; $display("FAIL reset_outs0: got %h want 0", {if0.fifo_rd_en, if0.m_valid, if0.m_last, if0.m_data, busy0});
      end
      nvec++;
      if ({if1.fifo_rd_en, if1.m_valid, if1.m_last, if1.m_data, busy1} !== 20'h0) begin
         nerr++; $display("FAIL reset_outs1: got %h want 0", {if1.fifo_rd_en, if1.m_valid, if1.m_last, if1.m_data, busy1});
      end
      @(negedge clk);
      rstn = 1'b1; en0 = 1'b1; en1 = 1'b1; hits = 0;
      repeat (20) begin
         @(negedge clk);
         if (if0.fifo_rd_en || if1.fifo_rd_en || busy0 || busy1) hits++;
      end
      nvec++;
      if (hits !== 0) begin
         nerr++; $display("FAIL reset_idle: got %0d active cycles want 0", hits);
      end
      en0 = 1'b0; en1 = 1'b0;
   endtask

   task automatic test_single_word();
      int rc, nrd;
      logic [8:0] got[$];
      int vcyc[$];
      en0 = 1'b1; if0.m_ready = 1'b1;
      push0(16'hA55A);
      rc = -1; nrd = 0;
      for (int c = 0; c < 12; c++) begin
         if (if0.fifo_rd_en) begin nrd++; if (rc < 0) rc = c; end
         if (if0.m_valid) begin got.push_back({if0.m_last, if0.m_data}); vcyc.push_back(c); end
         @(negedge clk);
      end
      nvec++;
      if (nrd !== 1) begin nerr++; $display("FAIL single_rd_count: got %0d want 1", nrd); end
      nvec++;
      if (got.size() !== 2) begin
         nerr++; $display("FAIL single_beat_count: got %0d want 2", got.size());
      end else begin
         nvec++;
         if (vcyc[0] !== rc + 2) begin nerr++; $display("FAIL single_latency: got cycle %0d want %0d", vcyc[0], rc + 2); end
         nvec++;
         if (got[0] !== 9'h0A5) begin nerr++; $display("FAIL single_beat0: got %h want %h", got[0], 9'h0A5); end
         nvec++;
         if (got[1] !== 9'h15A) begin nerr++; $display("FAIL single_beat1: got %h want %h", got[1], 9'h15A); end
      end
      nvec++;
      if (busy0 !== 1'b0) begin nerr++; $display("FAIL single_busy: got %b want 0", busy0); end
   endtask

   task automatic test_streaming();
      logic [15:0] w[3];
      logic [8:0]  got[$];
      int          vcyc[$];
      w[0] = 16'h0102; w[1] = 16'h0304; w[2] = 16'h0506;
      en0 = 1'b0; if0.m_ready = 1'b1;
      for (int i = 0; i < 3; i++) push0(w[i]);
      en0 = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (if0.m_valid) begin got.push_back({if0.m_last, if0.m_data}); vcyc.push_back(c); end
         @(negedge clk);
      end
      nvec++;
      if (got.size() !== 6) begin
         nerr++; $display("FAIL stream_count: got %0d want 6", got.size());
      end else begin
         nvec++;
         if (vcyc[5] - vcyc[0] !== 5) begin nerr++; $display("FAIL stream_gaps: got span %0d want 5", vcyc[5] - vcyc[0]); end
         for (int i = 0; i < 6; i++) begin
            nvec++;
            if (got[i] !== ref8(w[i / 2], i % 2)) begin
               nerr++; $display("FAIL stream_beat%0d: got %h want %h", i, got[i], ref8(w[i / 2], i % 2));
            end
         end
      end
      en0 = 1'b0;
   endtask

   task automatic test_back_pressure();
      logic [15:0] w[8];
      int r0, base, bad;
      en0 = 1'b0; if0.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin w[i] = 16'($urandom); push0(w[i]); end
      r0 = rdcnt0; base = cap0.size(); bad = 0;
      en0 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c >= 2 && (!if0.m_valid || if0.m_data !== w[0][15:8])) bad++;
         @(negedge clk);
      end
      nvec++;
      if (bad !== 0) begin nerr++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
      nvec++;
      if (rdcnt0 - r0 !== 3) begin nerr++; $display("FAIL bp_reads: got %0d want 3", rdcnt0 - r0); end
      nvec++;
      if (busy0 !== 1'b1) begin nerr++; $display("FAIL bp_busy: got %b want 1", busy0); end
      if0.m_ready = 1'b1;
      for (int i = 0; i < 60 && cap0.size() < base + 16; i++) @(negedge clk);
      nvec++;
      if (cap0.size() !== base + 16) begin
         nerr++; $display("FAIL bp_count: got %0d want 16", cap0.size() - base);
      end else begin
         for (int i = 0; i < 16; i++) begin
            nvec++;
            if (cap0[base + i] !== ref8(w[i / 2], i % 2)) begin
               nerr++; $display("FAIL bp_beat%0d: got %h want %h", i, cap0[base + i], ref8(w[i / 2], i % 2));
            end
         end
      end
      nvec++;
      if (viol0 !== 0) begin nerr++; $display("FAIL bp_protocol: got %0d violations want 0", viol0); end
      en0 = 1'b0;
   endtask

   task automatic test_ratio1();
      logic [15:0] w[8];
      logic [16:0] got[$];
      int          vcyc[$];
      en1 = 1'b0; if1.m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin w[i] = 16'($urandom); push1(w[i]); end
      en1 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (if1.m_valid) begin got.push_back({if1.m_last, if1.m_data}); vcyc.push_back(c); end
         @(negedge clk);
      end
      nvec++;
      if (got.size() !== 8) begin
         nerr++; $display("FAIL r1_count: got %0d want 8", got.size());
      end else begin
         nvec++;
         if (vcyc[7] - vcyc[0] !== 7) begin nerr++; $display("FAIL r1_gaps: got span %0d want 7", vcyc[7] - vcyc[0]); end
         for (int i = 0; i < 8; i++) begin
            nvec++;
            if (got[i] !== {1'b1, w[i]}) begin
               nerr++; $display("FAIL r1_beat%0d: got %h want %h", i, got[i], {1'b1, w[i]});
            end
         end
      end
      en1 = 1'b0;
   endtask

   task automatic test_random();
      logic [8:0]  exp0[$];
      logic [16:0] exp1[$];
      int base0, base1;
      base0 = cap0.size(); base1 = cap1.size();
      for (int c = 0; c < 600; c++) begin
         en0 = ($urandom_range(0, 7) != 0);
         en1 = ($urandom_range(0, 7) != 0);
         if0.m_ready = ($urandom_range(0, 3) != 0);
         if1.m_ready = ($urandom_range(0, 3) != 0);
         wr0 = ($urandom_range(0, 3) == 0);
         wr1 = ($urandom_range(0, 1) == 0);
         wd0 = 16'($urandom); wd1 = 16'($urandom);
         if (wr0) begin exp0.push_back(ref8(wd0, 0)); exp0.push_back(ref8(wd0, 1)); end
         if (wr1) exp1.push_back({1'b1, wd1});
         @(negedge clk);
      end
      wr0 = 1'b0; wr1 = 1'b0; en0 = 1'b1; en1 = 1'b1;
      if0.m_ready = 1'b1; if1.m_ready = 1'b1;
      for (int i = 0; i < 1000 && (cap0.size() < base0 + exp0.size() || cap1.size() < base1 + exp1.size()); i++)
         @(negedge clk);
      tick(4);
      nvec++;
      if (cap0.size() - base0 !== exp0.size()) begin
         nerr++; $display("FAIL rand0_count: got %0d want %0d", cap0.size() - base0, exp0.size());
      end else begin
         for (int i = 0; i < exp0.size(); i++) begin
            nvec++;
            if (cap0[base0 + i] !== exp0[i]) begin
               nerr++; $display("FAIL rand0_beat%0d: got %h want %h", i, cap0[base0 + i], exp0[i]);
            end
         end
      end
      nvec++;
      if (cap1.size() - base1 !== exp1.size()) begin
         nerr++; $display("FAIL rand1_count: got %0d want %0d", cap1.size() - base1, exp1.size());
      end else begin
         for (int i = 0; i < exp1.size(); i++) begin
            nvec++;
            if (cap1[base1 + i] !== exp1[i]) begin
               nerr++; $display("FAIL rand1_beat%0d: got %h want %h", i, cap1[base1 + i], exp1[i]);
            end
         end
      end
      nvec++;
      if (viol0 + viol1 !== 0) begin nerr++; $display("FAIL rand_protocol: got %0d violations want 0", viol0 + viol1); end
      en0 = 1'b0; en1 = 1'b0;
   endtask

   task automatic test_reset_mid_word();
      int base;
      en0 = 1'b1; if0.m_ready = 1'b1;
      base = cap0.size();
      push0(16'hBEEF);
      for (int i = 0; i < 20 && cap0.size() == base; i++) @(negedge clk);
      if0.m_ready = 1'b0;
      nvec++;
      if (cap0.size() !== base + 1) begin
         nerr++; $display("FAIL mid_first_count: got %0d want 1", cap0.size() - base);
      end else begin
         nvec++;
         if (cap0[base] !== 9'h0BE) begin nerr++; $display("FAIL mid_beat0: got %h want %h", cap0[base], 9'h0BE); end
      end
      nvec++;
      if ({if0.m_valid, if0.m_data} !== 9'h1EF) begin
         nerr++; $display("FAIL mid_pending: got %h want %h", {if0.m_valid, if0.m_data}, 9'h1EF);
      end
      #2 rstn = 1'b0;
      #1;
      nvec++;
      if ({if0.m_valid, if0.m_last, if0.m_data, busy0} !== 11'h0) begin
         nerr++; $display("FAIL mid_reset_outs: got %h want 0", {if0.m_valid, if0.m_last, if0.m_data, busy0});
      end
      @(negedge clk);
      rstn = 1'b1; if0.m_ready = 1'b1;
      tick(10);
      nvec++;
      if (cap0.size() !== base + 1) begin
         nerr++; $display("FAIL mid_no_tail: got %0d beats want 1", cap0.size() - base);
      end
      push0(16'h1234);
      for (int i = 0; i < 20 && cap0.size() < base + 3; i++) @(negedge clk);
      nvec++;
      if (cap0.size() !== base + 3) begin
         nerr++; $display("FAIL mid_post_count: got %0d want 3", cap0.size() - base);
      end else begin
         nvec++;
         if ({cap0[base + 1], cap0[base + 2]} !== {ref8(16'h1234, 0), ref8(16'h1234, 1)}) begin
            nerr++; $display("FAIL mid_post_beats: got %h %h want %h %h", cap0[base + 1], cap0[base + 2],
                             ref8(16'h1234, 0), ref8(16'h1234, 1));
         end
      end
      en0 = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0;
      en0 = 1'b0; en1 = 1'b0;
      wr0 = 1'b0; wr1 = 1'b0; wd0 = '0; wd1 = '0;
      if0.m_ready = 1'b0; if1.m_ready = 1'b0;
      tick(3);
      rstn = 1'b1;
      tick(2);
      test_reset();
      test_single_word();
      test_streaming();
      test_back_pressure();
      test_ratio1();
      test_random();
      test_reset_mid_word();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
